// File: rtl/uc_arbiter.sv
// Unit clause arbiter: round-robin pushes engine literals into the shared unit
// clause queue and broadcasts each popped literal until every engine has acked.
module uc_arbiter #(
  parameter  int NUM_ENG  = 4,
  parameter  int DATA_LEN = 512,
  localparam int LIT_W    = $clog2(DATA_LEN),
  localparam int PTR_W    = $clog2(NUM_ENG)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_ENG-1:0]       eng_req,
  input  logic [NUM_ENG*LIT_W-1:0] eng_lit,
  output logic [NUM_ENG-1:0]       eng_gnt,
  input  logic                     ucq_full,
  input  logic                     ucq_empty,
  input  logic [LIT_W-1:0]         ucq_head,
  output logic                     ucq_push,
  output logic [LIT_W-1:0]         ucq_data,
  output logic                     ucq_pop,
  output logic                     bc_valid,
  output logic [LIT_W-1:0]         bc_lit,
  input  logic [NUM_ENG-1:0]       eng_ack,
  output logic                     busy
);

  typedef enum logic {IDLE, BCAST} state_t;

  logic [LIT_W-1:0]   lit_arr [NUM_ENG];
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   cand;
  logic               gnt_found;
  logic               push_ok;

  state_t             state_q;
  logic [NUM_ENG-1:0] ack_mask_q;
  logic [LIT_W-1:0]   bc_lit_q;
  logic               bc_valid_q;
  logic               done;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENG; gi++) begin : g_lit
      assign lit_arr[gi] = eng_lit[gi*LIT_W +: LIT_W];
    end
  endgenerate

  // Search starts at rr_ptr_q; PTR_W-bit addition wraps modulo NUM_ENG.
  always_comb begin
    gnt_idx   = '0;
    gnt_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_ENG; k++) begin
      cand = rr_ptr_q + PTR_W'(k);
      if (!gnt_found && eng_req[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign push_ok  = gnt_found && !ucq_full && !rst;
  assign ucq_push = push_ok;
  assign ucq_data = lit_arr[gnt_idx];

  generate
    for (gi = 0; gi < NUM_ENG; gi++) begin : g_gnt
      assign eng_gnt[gi] = push_ok && (gnt_idx == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else if (push_ok) begin
      rr_ptr_q <= gnt_idx + PTR_W'(1);
    end
  end

  // Current-cycle acks count toward completion so a single-cycle ack retires at once.
  assign done    = &(ack_mask_q | eng_ack);
  assign ucq_pop = !rst && !ucq_empty && ((state_q == IDLE) || done);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ack_mask_q <= '0;
      bc_lit_q   <= '0;
      bc_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!ucq_empty) begin
            state_q    <= BCAST;
            bc_lit_q   <= ucq_head;
            ack_mask_q <= '0;
            bc_valid_q <= 1'b1;
          end
        end
        BCAST: begin
          if (!done) begin
            ack_mask_q <= ack_mask_q | eng_ack;
          end else if (!ucq_empty) begin
            bc_lit_q   <= ucq_head;
            ack_mask_q <= '0;
          end else begin
            state_q    <= IDLE;
            ack_mask_q <= '0;
            bc_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          bc_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bc_valid = bc_valid_q;
  assign bc_lit   = bc_lit_q;
  assign busy     = bc_valid_q || !ucq_empty;

endmodule

// File: tb/tb_uc_arbiter.sv
// Directed bench for uc_arbiter: stimulus queues expected pushes, broadcasts and
// per-cycle control values; a negedge monitor pops and compares them.
module tb_uc_arbiter;

  localparam int NUM_ENG = 4;
  localparam int LIT_W   = 9;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_ENG-1:0]       eng_req;
  logic [NUM_ENG*LIT_W-1:0] eng_lit;
  logic [NUM_ENG-1:0]       eng_gnt;
  logic                     ucq_full;
  logic                     ucq_empty;
  logic [LIT_W-1:0]         ucq_head;
  logic                     ucq_push;
  logic [LIT_W-1:0]         ucq_data;
  logic                     ucq_pop;
  logic                     bc_valid;
  logic [LIT_W-1:0]         bc_lit;
  logic [NUM_ENG-1:0]       eng_ack;
  logic                     busy;

  always #5 clk = ~clk;

  uc_arbiter #(.NUM_ENG(NUM_ENG), .DATA_LEN(512)) dut (
    .clk(clk), .rst(rst),
    .eng_req(eng_req), .eng_lit(eng_lit), .eng_gnt(eng_gnt),
    .ucq_full(ucq_full), .ucq_empty(ucq_empty), .ucq_head(ucq_head),
    .ucq_push(ucq_push), .ucq_data(ucq_data), .ucq_pop(ucq_pop),
    .bc_valid(bc_valid), .bc_lit(bc_lit), .eng_ack(eng_ack), .busy(busy)
  );

  typedef struct packed {
    logic [NUM_ENG-1:0] gnt;
    logic [LIT_W-1:0]   data;
  } push_t;

  typedef enum int {F_GNT, F_PUSH, F_POP, F_BCV, F_BCL, F_BUSY,
                    F_POPCNT, F_PUSHQ, F_BCQ} field_e;

  typedef struct {
    field_e f;
    int     exp;
  } chk_t;

  push_t            push_q [$];
  logic [LIT_W-1:0] bc_q   [$];
  chk_t             chk_q  [$];

  int n_vec   = 0;
  int n_err   = 0;
  int pop_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin : monitor
    push_t            p;
    logic [LIT_W-1:0] e;
    chk_t             c;
    logic             prev_pop;
    prev_pop = 1'b0;
    forever begin
      @(negedge clk);
      if (ucq_pop) begin
        pop_cnt++;
        check("pop_while_empty", int'(ucq_empty), 0);
      end
      if (eng_gnt != '0 || ucq_push) begin
        if (push_q.size() == 0) begin
          check("unexpected_push", int'({eng_gnt, ucq_push}), 0);
        end else begin
          p = push_q.pop_front();
          check("push_gnt", int'(eng_gnt), int'(p.gnt));
          check("push_strobe", int'(ucq_push), 1);
          check("push_data", int'(ucq_data), int'(p.data));
          $display("push   gnt=%b data=%0d", eng_gnt, ucq_data);
        end
      end
      if (prev_pop) begin
        if (bc_q.size() == 0) begin
          check("unexpected_bcast", 1, 0);
        end else begin
          e = bc_q.pop_front();
          check("bc_valid_after_pop", int'(bc_valid), 1);
          check("bc_lit", int'(bc_lit), int'(e));
          $display("bcast  lit=%0d", bc_lit);
        end
      end
      prev_pop = ucq_pop;
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        case (c.f)
          F_GNT:    check("eng_gnt",   int'(eng_gnt),  c.exp);
          F_PUSH:   check("ucq_push",  int'(ucq_push), c.exp);
          F_POP:    check("ucq_pop",   int'(ucq_pop),  c.exp);
          F_BCV:    check("bc_valid",  int'(bc_valid), c.exp);
          F_BCL:    check("bc_lit_hold", int'(bc_lit), c.exp);
          F_BUSY:   check("busy",      int'(busy),     c.exp);
          F_POPCNT: check("pop_count", pop_cnt,        c.exp);
          F_PUSHQ:  check("push_left", push_q.size(),  c.exp);
          F_BCQ:    check("bcast_left", bc_q.size(),   c.exp);
          default:  check("bad_field", 1, 0);
        endcase
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic want(input field_e f, input int e);
    chk_t c;
    c.f   = f;
    c.exp = e;
    chk_q.push_back(c);
  endtask

  task automatic want_push(input logic [NUM_ENG-1:0] g, input logic [LIT_W-1:0] d);
    push_t p;
    p.gnt  = g;
    p.data = d;
    push_q.push_back(p);
  endtask

  initial begin : stim
    rst       = 1'b1;
    eng_req   = '0;
    eng_lit   = {9'd40, 9'd30, 9'd20, 9'd10};
    ucq_full  = 1'b0;
    ucq_empty = 1'b1;
    ucq_head  = '0;
    eng_ack   = '0;
    want(F_GNT, 0); want(F_PUSH, 0); want(F_POP, 0); want(F_BCV, 0);
    cyc();
    // Still in reset: requests and a non-empty queue must be ignored.
    eng_req = 4'b1111; ucq_empty = 1'b0; ucq_head = 9'd3;
    want(F_GNT, 0); want(F_PUSH, 0); want(F_POP, 0); want(F_BCV, 0);
    cyc();
    rst = 1'b0; eng_req = '0; ucq_empty = 1'b1;
    want(F_GNT, 0); want(F_PUSH, 0); want(F_POP, 0); want(F_BCV, 0);
    want(F_BUSY, 0); want(F_BCL, 0); want(F_POPCNT, 0);
    cyc();

    // Round-robin over all four requesters, wrapping back to engine 0.
    eng_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      want_push(4'(1 << (k % 4)), 9'((k % 4 + 1) * 10));
      cyc();
    end

    // Full stall with engine 2 requesting; pointer sits at 1.
    eng_req = 4'b0100; ucq_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      want(F_GNT, 0); want(F_PUSH, 0);
      cyc();
    end
    ucq_full = 1'b0;
    want_push(4'b0100, 9'd30);
    cyc();
    eng_req = 4'b1111;             // pointer is now 3
    want_push(4'b1000, 9'd40);
    cyc();
    eng_req = 4'b0110;             // pointer 0: skip idle engine 0
    want_push(4'b0010, 9'd20);
    cyc();
    want_push(4'b0100, 9'd30);
    cyc();
    eng_req = 4'b0001;             // pointer 3: wrap to engine 0
    want_push(4'b0001, 9'd10);
    cyc();
    eng_req = '0;
    want(F_GNT, 0); want(F_PUSH, 0);
    cyc();

    // Staggered acks on a single broadcast.
    ucq_empty = 1'b0; ucq_head = 9'd37; bc_q.push_back(9'd37);
    want(F_POP, 1); want(F_BCV, 0); want(F_BUSY, 1);
    cyc();
    ucq_empty = 1'b1; eng_ack = 4'b0001;
    want(F_BCV, 1); want(F_BCL, 37); want(F_POP, 0); want(F_BUSY, 1);
    cyc();
    eng_ack = 4'b1010;
    want(F_BCV, 1); want(F_POP, 0);
    cyc();
    eng_ack = 4'b0000;
    want(F_BCV, 1);
    cyc();
    eng_ack = 4'b0100;
    want(F_BCV, 1); want(F_BCL, 37); want(F_POP, 0);
    cyc();
    eng_ack = 4'b0000;
    want(F_BCV, 0); want(F_BUSY, 0); want(F_POPCNT, 1);
    cyc();

    // Back-to-back broadcasts of 5, 6, 7 with every engine acking at once.
    eng_ack = 4'b1111; ucq_empty = 1'b0; ucq_head = 9'd5; bc_q.push_back(9'd5);
    want(F_POP, 1); want(F_BCV, 0);
    cyc();
    ucq_head = 9'd6; bc_q.push_back(9'd6);
    want(F_POP, 1); want(F_BCV, 1);
    cyc();
    ucq_head = 9'd7; bc_q.push_back(9'd7);
    want(F_POP, 1); want(F_BCV, 1);
    cyc();
    ucq_empty = 1'b1;
    want(F_POP, 0); want(F_BCV, 1); want(F_BCL, 7);
    cyc();
    eng_ack = '0;
    want(F_BCV, 0); want(F_POPCNT, 4);
    cyc();

    // Reset in the middle of a broadcast with ack_mask = 0011.
    ucq_empty = 1'b0; ucq_head = 9'd99; bc_q.push_back(9'd99);
    want(F_POP, 1);
    cyc();
    ucq_empty = 1'b1; eng_ack = 4'b0011;
    want(F_BCV, 1); want(F_BCL, 99);
    cyc();
    rst = 1'b1; eng_ack = '0; ucq_empty = 1'b0; ucq_head = 9'd55; eng_req = 4'b1111;
    want(F_POP, 0); want(F_GNT, 0); want(F_PUSH, 0);
    cyc();
    rst = 1'b0; bc_q.push_back(9'd55);
    want_push(4'b0001, 9'd10);     // pointer back at 0 after reset
    want(F_BCV, 0); want(F_BCL, 0); want(F_POP, 1);
    cyc();
    eng_req = '0; ucq_empty = 1'b1; eng_ack = 4'b1100;
    want(F_BCV, 1); want(F_BCL, 55);
    cyc();
    eng_ack = 4'b0011;
    want(F_BCV, 1);
    cyc();
    eng_ack = '0;
    want(F_BCV, 0); want(F_BUSY, 0); want(F_POPCNT, 6);
    want(F_PUSHQ, 0); want(F_BCQ, 0);
    cyc();

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uc_arbiter.md
Name: uc_arbiter

Overview:
- Unit Clause Arbiter (uca) sitting between the process engines (eng) and the shared Unit Clause Queue (ucq).
- Push side: round-robin arbitrates unit-clause literals from NUM_ENG engines into the ucq, at most one push per cycle.
- Pop side: pops the ucq head and broadcasts the literal to all engines. It holds the broadcast until every engine has acknowledged, then retires it.

Parameters:
- NUM_ENG, 4, number of process engines (requesters and broadcast consumers); power of 2, at least 2.
- DATA_LEN, 512, literal space; LIT_W = $clog2(DATA_LEN) = 9 bits per literal.

Ports:
- clk, input, 1, single clock.
- rst, input, 1, synchronous active-high reset.
- eng_req, input, NUM_ENG, engine i has a unit literal to push; held high until granted.
- eng_lit, input, NUM_ENG x LIT_W, literal from engine i; stable while eng_req[i]=1.
- eng_gnt, output, NUM_ENG, one-hot or zero; combinational grant, same cycle as the push.
- ucq_full, input, 1, ucq full flag.
- ucq_empty, input, 1, ucq empty flag.
- ucq_head, input, LIT_W, literal at the ucq head (valid when ucq_empty=0).
- ucq_push, output, 1, push strobe to the ucq.
- ucq_data, output, LIT_W, literal being pushed (eng_lit of the granted engine).
- ucq_pop, output, 1, pop strobe to the ucq.
- bc_valid, output, 1, a broadcast literal is presented to the engines.
- bc_lit, output, LIT_W, broadcast literal (registered).
- eng_ack, input, NUM_ENG, engine i has consumed bc_lit; sampled only while bc_valid=1.
- busy, output, 1, high if bc_valid=1 or ucq_empty=0.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - rr_ptr=0, state=IDLE, ack_mask=0, bc_lit=0.
  - Outputs: bc_valid=0, ucq_pop=0, ucq_push=0, eng_gnt=0.
  - Reset mid-broadcast drops the in-flight literal with no re-pop; ucq contents are the ucq's own concern.
- Push arbitration (combinational from registered rr_ptr):
  - If ucq_full=1: eng_gnt=0 and ucq_push=0.
  - Else: grant the first i with eng_req[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_ENG.
  - On a grant: eng_gnt[i]=1, ucq_push=1, ucq_data=eng_lit[i].
  - Next cycle rr_ptr = (i+1) mod NUM_ENG. With no grant, rr_ptr holds.
  - At most one grant per cycle. An engine that is not granted keeps its request; no request is lost.
  - Fairness: a continuously requesting engine is granted within NUM_ENG push opportunities.
- Broadcast FSM, two states: IDLE, BCAST.
  - IDLE: bc_valid=0. If ucq_empty=0, assert ucq_pop=1 (combinational), register bc_lit<=ucq_head and ack_mask<=0, then go to BCAST. Otherwise stay in IDLE.
  - BCAST: bc_valid=1 and bc_lit is held stable. Define done = &(ack_mask | eng_ack).
    - If done=0: ack_mask <= ack_mask | eng_ack (sticky); stay in BCAST.
    - If done=1 and ucq_empty=0: back-to-back. Assert ucq_pop, bc_lit<=ucq_head, ack_mask<=0, stay in BCAST.
    - If done=1 and ucq_empty=1: go to IDLE; bc_valid drops the next cycle.
  - Latency: ucq_empty falls at cycle t while IDLE -> ucq_pop at t -> bc_valid=1 at t+1.
  - Throughput: 1 literal/cycle when every engine acks in the same cycle it sees bc_valid.
  - Acks: an engine may ack in any cycle of the broadcast, including repeatedly; duplicate acks are harmless. eng_ack is ignored in IDLE.
  - ucq_pop is never asserted while ucq_empty=1.
- Push and pop in the same cycle are independent. The ucq handles the simultaneous case; the uca applies no ordering between the two sides.
- An empty->nonempty transition in the ucq is seen one cycle after the push, because ucq_empty is a registered input.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all inputs 0 -> eng_gnt=0, ucq_push=0, ucq_pop=0, bc_valid=0, busy=0.
- Round-robin: eng_req=4'b1111 held, lits 10/20/30/40, ucq_full=0 -> grants 0,1,2,3,0 on consecutive cycles; ucq_data=10,20,30,40,10.
- Full stall: eng_req=4'b0100, ucq_full=1 for 3 cycles, then 0 -> eng_gnt=0 for 3 cycles, then eng_gnt=4'b0100 with ucq_push=1; rr_ptr becomes 3.
- Staggered acks: ucq_head=9'd37, ucq_empty falls -> ucq_pop for 1 cycle, bc_valid=1 with bc_lit=37; ack engine 0 at c1, engines 1 and 3 at c2, engine 2 at c4 -> bc_valid stays 1 through c4, 0 at c5; exactly one pop.
- Back-to-back: ucq holds literals 5,6,7 and eng_ack=4'b1111 every cycle -> bc_lit=5,6,7 on 3 consecutive cycles, 3 pops, then IDLE.
- Reset mid-broadcast: rst at c2 of a BCAST with ack_mask=4'b0011 -> the next cycle bc_valid=0, state=IDLE, ack_mask=0; no ucq_pop during the rst cycle.
